// File: rtl/receive_fsm.sv
// CC2420 receive controller: drains one frame from the RXFIFO over the shared SPI
// byte engine, filters it on length/address/CRC and hands the payload out via valid/ready.
module receive_fsm #(
    parameter logic [31:0] TimeoutCycles = 32'd270000,
    parameter logic [7:0]  FrameLen      = 8'd11
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_so,
    input  logic        i_spi_done,
    input  logic        i_sfd,
    input  logic        i_fifop,
    input  logic [7:0]  i_my_addr,
    output logic [7:0]  o_command,
    output logic        o_cmd_strobe,
    output logic        o_spi_cs,
    output logic [31:0] o_dout,
    output logic [7:0]  o_src_addr_out,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic        o_receive_done,
    output logic        o_dropped,
    output logic [3:0]  o_cur_state
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FLUSH1 = 4'd1,
        S_FLUSH2 = 4'd2,
        S_WAIT   = 4'd3,
        S_RDCMD  = 4'd4,
        S_RDLEN  = 4'd5,
        S_RDBYTE = 4'd6,
        S_CHECK  = 4'd7,
        S_OUT    = 4'd8
    } state_t;

    localparam logic [7:0] CMD_SRXON    = 8'h03;
    localparam logic [7:0] CMD_SFLUSHRX = 8'h08;
    localparam logic [7:0] CMD_RXFIFO   = 8'h7F;
    localparam logic [7:0] CMD_NOP      = 8'h00;

    state_t      r_state, w_state_next;
    logic        r_busy, w_busy_next;
    logic [7:0]  r_command, w_command_next;
    logic        r_strobe, w_strobe_next;
    logic        r_cs, w_cs_next;
    logic [31:0] r_dout, w_dout_next;
    logic [7:0]  r_src_out, w_src_out_next;
    logic        r_valid, w_valid_next;
    logic        r_done, w_done_next;
    logic        r_dropped, w_dropped_next;
    logic [31:0] r_timer, w_timer_next;
    logic        r_armed, w_armed_next;
    logic [3:0]  r_byte_cnt, w_byte_cnt_next;
    logic        r_sfd_d;
    logic [7:0]  r_dst, w_dst_next;
    logic [7:0]  r_src, w_src_next;
    logic [7:0]  r_crc, w_crc_next;
    logic [31:0] r_data, w_data_next;

    logic        w_issue;
    logic [7:0]  w_cmd;
    logic        w_spi_evt;
    logic        w_sfd_rise;
    logic        w_addr_ok;

    assign w_spi_evt  = r_busy && i_spi_done;
    assign w_sfd_rise = i_sfd && !r_sfd_d;
    assign w_addr_ok  = (r_dst == i_my_addr) || (r_dst == 8'hFF);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_INIT;
            r_busy     <= 1'b0;
            r_command  <= 8'h00;
            r_strobe   <= 1'b0;
            r_cs       <= 1'b1;
            r_dout     <= 32'h0;
            r_src_out  <= 8'h00;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_dropped  <= 1'b0;
            r_timer    <= 32'h0;
            r_armed    <= 1'b0;
            r_byte_cnt <= 4'h0;
            r_sfd_d    <= 1'b0;
            r_dst      <= 8'h00;
            r_src      <= 8'h00;
            r_crc      <= 8'h00;
            r_data     <= 32'h0;
        end else begin
            r_state    <= w_state_next;
            r_busy     <= w_busy_next;
            r_command  <= w_command_next;
            r_strobe   <= w_strobe_next;
            r_cs       <= w_cs_next;
            r_dout     <= w_dout_next;
            r_src_out  <= w_src_out_next;
            r_valid    <= w_valid_next;
            r_done     <= w_done_next;
            r_dropped  <= w_dropped_next;
            r_timer    <= w_timer_next;
            r_armed    <= w_armed_next;
            r_byte_cnt <= w_byte_cnt_next;
            r_sfd_d    <= i_sfd;
            r_dst      <= w_dst_next;
            r_src      <= w_src_next;
            r_crc      <= w_crc_next;
            r_data     <= w_data_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_busy_next     = r_busy;
        w_command_next  = r_command;
        w_strobe_next   = 1'b0;
        w_cs_next       = r_cs;
        w_dout_next     = r_dout;
        w_src_out_next  = r_src_out;
        w_valid_next    = r_valid;
        w_done_next     = 1'b0;
        w_dropped_next  = 1'b0;
        w_timer_next    = r_timer;
        w_armed_next    = r_armed;
        w_byte_cnt_next = r_byte_cnt;
        w_dst_next      = r_dst;
        w_src_next      = r_src;
        w_crc_next      = r_crc;
        w_data_next     = r_data;
        w_issue         = 1'b0;
        w_cmd           = CMD_NOP;

        if (w_spi_evt) begin
            w_busy_next = 1'b0;
        end

        case (r_state)
            S_INIT: begin
                w_issue = 1'b1;
                w_cmd   = CMD_SRXON;
                if (w_spi_evt) begin
                    w_cs_next    = 1'b1;
                    w_state_next = S_FLUSH1;
                end
            end
            S_FLUSH1: begin
                w_issue = 1'b1;
                w_cmd   = CMD_SFLUSHRX;
                if (w_spi_evt) begin
                    w_cs_next    = 1'b1;
                    w_state_next = S_FLUSH2;
                end
            end
            S_FLUSH2: begin
                w_issue = 1'b1;
                w_cmd   = CMD_SFLUSHRX;
                if (w_spi_evt) begin
                    w_cs_next    = 1'b1;
                    w_armed_next = 1'b0;
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // The timeout only runs once an SFD edge has armed it.
                if (i_fifop) begin
                    w_armed_next = 1'b0;
                    w_state_next = S_RDCMD;
                end else if (w_sfd_rise) begin
                    w_timer_next = TimeoutCycles;
                    w_armed_next = 1'b1;
                end else if (r_armed) begin
                    if (r_timer == 32'd0) begin
                        w_armed_next   = 1'b0;
                        w_dropped_next = 1'b1;
                        w_state_next   = S_FLUSH1;
                    end else begin
                        w_timer_next = r_timer - 32'd1;
                    end
                end
            end
            S_RDCMD: begin
                w_issue = 1'b1;
                w_cmd   = CMD_RXFIFO;
                if (w_spi_evt) begin
                    w_state_next = S_RDLEN;
                end
            end
            S_RDLEN: begin
                w_issue = 1'b1;
                w_cmd   = CMD_NOP;
                if (w_spi_evt) begin
                    if (i_so != FrameLen) begin
                        w_cs_next      = 1'b1;
                        w_dropped_next = 1'b1;
                        w_state_next   = S_FLUSH1;
                    end else begin
                        w_byte_cnt_next = 4'd0;
                        w_state_next    = S_RDBYTE;
                    end
                end
            end
            S_RDBYTE: begin
                w_issue = 1'b1;
                w_cmd   = CMD_NOP;
                if (w_spi_evt) begin
                    case (r_byte_cnt)
                        4'd3:                      w_dst_next  = i_so;
                        4'd4:                      w_src_next  = i_so;
                        4'd5, 4'd6, 4'd7, 4'd8:    w_data_next = {r_data[23:0], i_so};
                        4'd10:                     w_crc_next  = i_so;
                        default: ;
                    endcase
                    if (r_byte_cnt == 4'd10) begin
                        w_cs_next    = 1'b1;
                        w_state_next = S_CHECK;
                    end else begin
                        w_byte_cnt_next = r_byte_cnt + 4'd1;
                    end
                end
            end
            S_CHECK: begin
                if (w_addr_ok && r_crc[7]) begin
                    w_dout_next    = r_data;
                    w_src_out_next = r_src;
                    w_valid_next   = 1'b1;
                    w_state_next   = S_OUT;
                end else begin
                    w_dropped_next = 1'b1;
                    w_state_next   = S_FLUSH1;
                end
            end
            S_OUT: begin
                if (i_out_ready) begin
                    w_valid_next = 1'b0;
                    w_done_next  = 1'b1;
                    w_state_next = i_fifop ? S_RDCMD : S_WAIT;
                end
            end
            default: begin
                w_busy_next  = 1'b0;
                w_cs_next    = 1'b1;
                w_state_next = S_INIT;
            end
        endcase

        // One outstanding transfer: a command state strobes once, then waits for SpiDone.
        if (w_issue && !r_busy) begin
            w_command_next = w_cmd;
            w_strobe_next  = 1'b1;
            w_busy_next    = 1'b1;
            w_cs_next      = 1'b0;
        end
    end

    assign o_command      = r_command;
    assign o_cmd_strobe   = r_strobe;
    assign o_spi_cs       = r_cs;
    assign o_dout         = r_dout;
    assign o_src_addr_out = r_src_out;
    assign o_out_valid    = r_valid;
    assign o_receive_done = r_done;
    assign o_dropped      = r_dropped;
    assign o_cur_state    = r_state;

endmodule

// File: tb/tb_receive_fsm.sv
// Directed bench for receive_fsm: behavioural SPI byte engine plus a table of frames
// and hand-written sequences for timeout, backpressure and reset mid-burst.
module tb_receive_fsm;

    localparam logic [31:0] TO_CYC = 32'd40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  so;
    logic        spi_done;
    logic        sfd;
    logic        fifop;
    logic [7:0]  my_addr;
    logic [7:0]  o_command;
    logic        o_cmd_strobe;
    logic        o_spi_cs;
    logic [31:0] o_dout;
    logic [7:0]  o_src_addr_out;
    logic        o_out_valid;
    logic        out_ready;
    logic        o_receive_done;
    logic        o_dropped;
    logic [3:0]  o_cur_state;

    always #5 clk = ~clk;

    receive_fsm #(.TimeoutCycles(TO_CYC), .FrameLen(8'd11)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_so(so), .i_spi_done(spi_done),
        .i_sfd(sfd), .i_fifop(fifop), .i_my_addr(my_addr),
        .o_command(o_command), .o_cmd_strobe(o_cmd_strobe), .o_spi_cs(o_spi_cs),
        .o_dout(o_dout), .o_src_addr_out(o_src_addr_out), .o_out_valid(o_out_valid),
        .i_out_ready(out_ready), .o_receive_done(o_receive_done),
        .o_dropped(o_dropped), .o_cur_state(o_cur_state)
    );

    typedef struct {
        logic [7:0]  my_addr;
        logic [7:0]  len;
        logic [7:0]  dst;
        logic [7:0]  src;
        logic [31:0] data;
        logic [7:0]  crc;
        logic        exp_accept;
        int          exp_reads;
        logic [31:0] exp_dout;
        logic [7:0]  exp_src;
    } vec_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] so_q[$];
    logic [7:0] log_q[$];
    logic [7:0] exp_q[$];
    int         proto_err = 0;
    int         coincide_err = 0;
    logic       valid_seen = 1'b0;

    // SPI byte engine: answers each strobe two cycles later with the next queued byte.
    initial begin
        logic       pending;
        logic [7:0] pend_cmd;
        int         cd;
        pending = 1'b0; pend_cmd = 8'h00; cd = 0;
        spi_done = 1'b0; so = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending  = 1'b0;
                spi_done = 1'b0;
                cd       = 0;
            end else begin
                spi_done = 1'b0;
                if (pending && (o_command !== pend_cmd || o_spi_cs !== 1'b0))
                    proto_err++;
                if (o_cmd_strobe) begin
                    if (pending) proto_err++;
                    log_q.push_back(o_command);
                    pend_cmd = o_command;
                    pending  = 1'b1;
                    cd       = 2;
                end else if (pending) begin
                    if (cd > 1) begin
                        cd--;
                    end else begin
                        so       = (so_q.size() > 0) ? so_q.pop_front() : 8'h00;
                        spi_done = 1'b1;
                        pending  = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (o_out_valid) valid_seen = 1'b1;
            if (o_dropped && o_receive_done) coincide_err++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic check_log(input string name);
        int bad;
        bad = 0;
        check({name, "_len"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            if (log_q[i] !== exp_q[i]) bad++;
        check({name, "_bytes"}, bad, 0);
    endtask

    task automatic wait_state(input logic [3:0] s, input int bound, input string name);
        int n;
        n = 0;
        while (o_cur_state !== s && n < bound) begin
            tick();
            n++;
        end
        check(name, o_cur_state, s);
    endtask

    task automatic load_frame(input vec_t v);
        so_q.delete();
        so_q.push_back(8'hA5);
        so_q.push_back(v.len);
        so_q.push_back(8'h41);
        so_q.push_back(8'h88);
        so_q.push_back(8'h01);
        so_q.push_back(v.dst);
        so_q.push_back(v.src);
        so_q.push_back(v.data[31:24]);
        so_q.push_back(v.data[23:16]);
        so_q.push_back(v.data[15:8]);
        so_q.push_back(v.data[7:0]);
        so_q.push_back(8'h50);
        so_q.push_back(v.crc);
    endtask

    task automatic expect_reads(input int n_reads, input logic flushed);
        exp_q.delete();
        exp_q.push_back(8'h7F);
        for (int i = 0; i < n_reads; i++) exp_q.push_back(8'h00);
        if (flushed) begin
            exp_q.push_back(8'h08);
            exp_q.push_back(8'h08);
        end
    endtask

    task automatic wait_outcome(input string name);
        int n;
        n = 0;
        while (!o_out_valid && !o_dropped && n < 2000) begin
            tick();
            n++;
        end
        check({name, "_outcome_in_time"}, (n < 2000), 1'b1);
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_done"}, o_receive_done, 1'b1);
        check({name, "_valid_cleared"}, o_out_valid, 1'b0);
        check({name, "_state_after"}, o_cur_state, 4'd3);
        tick();
        check({name, "_done_one_cycle"}, o_receive_done, 1'b0);
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        string nm;
        int    n;
        nm = $sformatf("frame%0d", idx);
        my_addr = v.my_addr;
        load_frame(v);
        log_q.delete();
        valid_seen = 1'b0;
        fifop = 1'b1;
        n = 0;
        while (o_cur_state == 4'd3 && n < 50) begin
            tick();
            n++;
        end
        fifop = 1'b0;
        wait_outcome(nm);
        check({nm, "_accept"}, o_out_valid, v.exp_accept);
        if (v.exp_accept) begin
            check({nm, "_dout"}, o_dout, v.exp_dout);
            check({nm, "_src"}, o_src_addr_out, v.exp_src);
            expect_reads(v.exp_reads, 1'b0);
            check_log({nm, "_cmds"});
            handshake(nm);
        end else begin
            check({nm, "_dropped"}, o_dropped, 1'b1);
            wait_state(4'd3, 500, {nm, "_back_to_wait"});
            check({nm, "_never_valid"}, valid_seen, 1'b0);
            expect_reads(v.exp_reads, 1'b1);
            check_log({nm, "_cmds"});
        end
    endtask

    vec_t vecs[6];

    initial begin
        vec_t v2;
        int   n;
        int   bp_err;

        vecs[0] = '{8'hCD, 8'h0B, 8'hCD, 8'hAB, 32'h12345678, 8'h80, 1'b1, 12, 32'h12345678, 8'hAB};
        vecs[1] = '{8'hCD, 8'h0B, 8'hEE, 8'hAB, 32'h12345678, 8'h80, 1'b0, 12, 32'h0, 8'h00};
        vecs[2] = '{8'hCD, 8'h0B, 8'hFF, 8'h5A, 32'hDEADBEEF, 8'hC3, 1'b1, 12, 32'hDEADBEEF, 8'h5A};
        vecs[3] = '{8'hCD, 8'h0C, 8'hCD, 8'hAB, 32'h12345678, 8'h80, 1'b0, 1, 32'h0, 8'h00};
        vecs[4] = '{8'hCD, 8'h0B, 8'hCD, 8'hAB, 32'h12345678, 8'h7F, 1'b0, 12, 32'h0, 8'h00};
        vecs[5] = '{8'h33, 8'h0B, 8'h33, 8'h9C, 32'h00000001, 8'hFF, 1'b1, 12, 32'h00000001, 8'h9C};

        rst_n = 1'b0; sfd = 1'b0; fifop = 1'b0; my_addr = 8'hCD; out_ready = 1'b0;
        tick();
        tick();
        check("rst_state", o_cur_state, 4'd0);
        check("rst_cs", o_spi_cs, 1'b1);
        check("rst_command", o_command, 8'h00);
        check("rst_strobe", o_cmd_strobe, 1'b0);
        check("rst_valid", o_out_valid, 1'b0);
        check("rst_dout", o_dout, 32'h0);
        check("rst_src", o_src_addr_out, 8'h00);
        check("rst_done", o_receive_done, 1'b0);
        check("rst_dropped", o_dropped, 1'b0);

        log_q.delete();
        rst_n = 1'b1;
        wait_state(4'd3, 500, "init_reach_wait");
        exp_q.delete();
        exp_q.push_back(8'h03); exp_q.push_back(8'h08); exp_q.push_back(8'h08);
        check_log("init_cmds");
        check("init_cs_idle", o_spi_cs, 1'b1);

        for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

        // Timeout: one SFD edge, FIFOP never rises.
        my_addr = 8'hCD;
        log_q.delete();
        sfd = 1'b1;
        n = 0;
        while (!o_dropped && n < int'(TO_CYC) + 20) begin
            tick();
            n++;
            if (n == 2) sfd = 1'b0;
        end
        sfd = 1'b0;
        check("timeout_dropped", o_dropped, 1'b1);
        check("timeout_not_early", (n >= int'(TO_CYC)), 1'b1);
        check("timeout_within_bound", (n <= int'(TO_CYC) + 2), 1'b1);
        wait_state(4'd3, 500, "timeout_back_to_wait");
        exp_q.delete();
        exp_q.push_back(8'h08); exp_q.push_back(8'h08);
        check_log("timeout_cmds");

        // Backpressure with FIFOP still high at release.
        v2 = '{8'hCD, 8'h0B, 8'hCD, 8'h77, 32'hCAFEF00D, 8'h80, 1'b1, 12, 32'hCAFEF00D, 8'h77};
        load_frame(v2);
        log_q.delete();
        fifop = 1'b1;
        wait_outcome("bp");
        check("bp_valid", o_out_valid, 1'b1);
        bp_err = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (o_out_valid !== 1'b1 || o_dout !== 32'hCAFEF00D || o_src_addr_out !== 8'h77)
                bp_err++;
        end
        check("bp_stable_errors", bp_err, 0);
        check("bp_no_extra_cmds", log_q.size(), 13);
        v2 = '{8'hCD, 8'h0B, 8'hCD, 8'h11, 32'h01020304, 8'h80, 1'b1, 12, 32'h01020304, 8'h11};
        load_frame(v2);
        log_q.delete();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_done", o_receive_done, 1'b1);
        check("bp_direct_rdcmd", o_cur_state, 4'd4);
        fifop = 1'b0;
        wait_outcome("bp2");
        check("bp2_dout", o_dout, 32'h01020304);
        check("bp2_src", o_src_addr_out, 8'h11);
        expect_reads(12, 1'b0);
        check_log("bp2_cmds");
        handshake("bp2");

        // Reset while RDBYTE index 6 is on the wire.
        load_frame(vecs[0]);
        log_q.delete();
        fifop = 1'b1;
        n = 0;
        while (log_q.size() < 9 && n < 500) begin
            tick();
            n++;
        end
        check("rstmid_reached_idx6", log_q.size(), 9);
        check("rstmid_state_before", o_cur_state, 4'd6);
        rst_n = 1'b0;
        #1;
        check("rstmid_cs", o_spi_cs, 1'b1);
        check("rstmid_valid", o_out_valid, 1'b0);
        check("rstmid_state", o_cur_state, 4'd0);
        fifop = 1'b0;
        tick();
        tick();
        log_q.delete();
        rst_n = 1'b1;
        wait_state(4'd3, 500, "rstmid_reach_wait");
        exp_q.delete();
        exp_q.push_back(8'h03); exp_q.push_back(8'h08); exp_q.push_back(8'h08);
        check_log("rstmid_cmds");

        check("spi_protocol_errors", proto_err, 0);
        check("done_drop_coincide", coincide_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/receive_fsm.md
Name: receive_fsm

Overview:
Receive-side counterpart of the CC2420 transmit controller. Waits for a completed frame in the radio RXFIFO and drains it over the shared SPI byte engine. Checks the length, the destination address and the radio CRC flag, then presents the 32-bit payload and the source address to the game logic through a valid/ready handshake. A bad frame is flushed from the radio and reported on Dropped.

Parameters:
TimeoutCycles, 32'd270000, Clock cycles allowed from an SFD rising edge to FIFOP assertion before the frame is abandoned (10 ms at 27 MHz).
FrameLen, 8'd11, Required value of the length byte (FCF0, FCF1, SEQ, DST, SRC, D3..D0, RSSI, CRC/LQI).

Ports:
Clock  input  1  system clock, 27 MHz
Reset  input  1  asynchronous, active-low reset (0 = reset)
SO  input  8  byte returned by the SPI engine for the last Command
SpiDone  input  1  one-cycle pulse; SO valid; SPI engine idle
SFD  input  1  radio start-of-frame delimiter pin
FIFOP  input  1  radio FIFOP pin; high = complete frame in RXFIFO
MyAddr  input  8  local node address
Command  output  8  byte for the SPI engine to shift out
CmdStrobe  output  1  one-cycle pulse; starts an SPI byte transfer of Command
SpiCS  output  1  chip select to the radio, active-low; held low across a burst
DOut  output  32  received payload {D3,D2,D1,D0}
SrcAddrOut  output  8  source address of the accepted frame
OutValid  output  1  DOut and SrcAddrOut are valid
OutReady  input  1  consumer accepts the word
ReceiveDone  output  1  one-cycle pulse on handshake completion
Dropped  output  1  one-cycle pulse when a frame is discarded
CurState  output  4  current state encoding, for debug and LEDs

Behaviour:
- Reset (Reset=0, asynchronous):
  - State goes to INIT(0).
  - SpiCS=1, Command=8'h00, CmdStrobe=0, OutValid=0, DOut=0, SrcAddrOut=0, ReceiveDone=0, Dropped=0.
  - Timeout counter and byte counter are cleared.
  - Reset asserted mid-burst abandons the burst immediately. After release the FSM starts again from INIT.
- Command issue: every command is one CmdStrobe pulse with Command held stable until SpiDone. Only one transfer is outstanding at a time.
- States and transitions (CurState encoding in parentheses):
  - INIT(0): send SRXON (8'h03) as a single-byte burst, then go to FLUSH1.
  - FLUSH1(1), FLUSH2(2): each sends SFLUSHRX (8'h08) as a single-byte burst. The radio requires two flushes. FLUSH2 goes to WAIT(3).
  - WAIT(3): leave on FIFOP=1 to RDCMD. On an SFD rising edge (registered compare) load the timeout counter. The counter decrements each cycle while FIFOP=0. When it reaches 0, pulse Dropped and go to FLUSH1.
  - RDCMD(4): SpiCS=0; send RXFIFO read (8'h7F); the returned status byte is ignored.
  - RDLEN(5): send 8'h00. On SpiDone, if SO != FrameLen, pulse Dropped and go to FLUSH1. Otherwise clear the byte counter and go to RDBYTE.
  - RDBYTE(6): send 8'h00 for each of the 11 bytes and capture by index:
    - index 0-2 (FCF0, FCF1, SEQ) are discarded;
    - index 3 is DST; index 4 is SRC;
    - index 5-8 are D3..D0, MSB first;
    - index 9 (RSSI) is discarded; index 10 is CRC/LQI.
    - After index 10, raise SpiCS and go to CHECK.
  - CHECK(7), one cycle:
    - Accept when DST==MyAddr or DST==8'hFF, and CRC/LQI bit7==1.
    - On accept, load DOut and SrcAddrOut, set OutValid=1, go to OUT.
    - Otherwise pulse Dropped and go to FLUSH1.
  - OUT(8): hold OutValid, DOut and SrcAddrOut stable until OutReady=1 is sampled. On that cycle:
    - clear OutValid;
    - pulse ReceiveDone on the next cycle;
    - go to WAIT, or directly to RDCMD if FIFOP is still high.
- Timing and boundary conditions:
  - OutReady held high before OutValid rises: the handshake completes on the first cycle of OUT.
  - SFD and FIFOP activity during OUT or a burst is ignored; the frame stays in the radio FIFO.
  - Dropped and ReceiveDone never pulse in the same cycle.
  - Unused encodings 9-15 return to INIT.

Test Plan:
1. Accepted frame. MyAddr=CD; after INIT, FIFOP=1; SO sequence 0B, 41, 88, 01, CD, AB, 12, 34, 56, 78, 50, 80.
   Required: commands 03, 08, 08, 7F, then twelve 00; OutValid=1 with DOut=32'h12345678 and SrcAddrOut=AB; OutReady=1 gives one ReceiveDone pulse and CurState=3.
2. Address filter. DST=EE gives Dropped, then two 08 commands, and OutValid never rises. DST=FF with MyAddr=CD is accepted.
3. Length and CRC. A length byte of 0C gives Dropped after RDLEN and no further 00 reads. A final byte of 7F (bit7=0) gives Dropped from CHECK.
4. Timeout. Pulse SFD and hold FIFOP=0 for TimeoutCycles+2 cycles. Required: Dropped pulse, flush, then back to WAIT.
5. Backpressure. Hold OutReady=0 for 100 cycles after OutValid; DOut stays stable. Release with FIFOP still high: RDCMD is entered without passing through WAIT.
6. Reset mid-burst. Drive Reset=0 at RDBYTE index 6. Required: SpiCS=1, OutValid=0 and CurState=0 immediately; after release, commands 03, 08, 08 are issued again.
